// File: rtl/conv_weight_loader.sv
// Serial-to-parallel loader for conv kernel weights: one word per handshake,
// packed with word 0 at the LSBs of the flat weight bus.
//
// state  | meaning
// S_IDLE | waiting for load_start, no words accepted
// S_LOAD | accepting words into slot[load_count]
// S_DONE | full kernel set held on weights, weights_valid = 1
module conv_weight_loader #(
  parameter int NUM_WEIGHTS = 36,
  parameter int DATA_WIDTH  = 16,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_start,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic [CNT_WIDTH-1:0]              load_count,
  output logic                              weights_valid,
  output logic [NUM_WEIGHTS*DATA_WIDTH-1:0] weights
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WEIGHTS - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_WEIGHTS);

  state_t                              state_q, state_d;
  logic [CNT_WIDTH-1:0]                cnt_q, cnt_d;
  logic                                valid_q, valid_d;
  logic [NUM_WEIGHTS*DATA_WIDTH-1:0]   weights_q, weights_d;
  logic                                accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      weights_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      weights_q <= weights_d;
    end
  end

  // load_start masks in_ready so a restart never swallows a beat
  assign in_ready = (state_q == S_LOAD) && !load_start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    weights_d = weights_q;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          cnt_d = '0;
        end else if (accept) begin
          for (int k = 0; k < NUM_WEIGHTS; k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
              weights_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
          end
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            cnt_d   = FULL_CNT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (load_start) begin
          state_d = S_LOAD;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign load_count    = cnt_q;
  assign weights_valid = valid_q;
  assign weights       = weights_q;

endmodule
